mem_ctrl_cmd_engine: RTL and testbench
======================================

# mem_ctrl_cmd_engine

Command engine that sits directly downstream of the mem_ctrl AXI4-Lite register slave. It consumes the decoded CTRL/ADDR/WDATA register values and executes multi-word fill (write) or checksum (read) sequences on a native BRAM port. It returns status, a read checksum and a completion interrupt back to the register file for AXI readback.

## Interface
- ADDR_WIDTH, 12: BRAM byte-address width.
- LEN_WIDTH, 8: word-count width.
- RD_LAT, 1: BRAM read latency in cycles; legal values are 1 and 2.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- cmd_start  in  1  single-cycle pulse, issued on a register write of CTRL[0]=1.
- cmd_op  in  1  0 = write fill, 1 = read checksum.
- cmd_len  in  LEN_WIDTH  number of words; 0 is legal.
- cmd_addr  in  ADDR_WIDTH  start byte address.
- cmd_wdata  in  32  first fill value (also the expected first read value).
- bram_en  out  1  BRAM access enable.
- bram_we  out  4  byte write enables.
- bram_addr  out  ADDR_WIDTH  BRAM byte address.
- bram_din  out  32  write data.
- bram_dout  in  32  read data, valid RD_LAT cycles after bram_en.
- sts_busy  out  1  command in progress.
- sts_done  out  1  sticky completion flag.
- sts_err  out  1  sticky misalignment error.
- sts_sum  out  32  read checksum.
- sts_count  out  LEN_WIDTH  words completed.
- sts_mismatch  out  LEN_WIDTH  read-compare mismatches (see Configuration).
- irq  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On cmd_start, latch all cmd_* inputs.
  - Clear sts_done, sts_err, sts_sum, sts_count and sts_mismatch.
  - Set sts_busy.
  - If cmd_addr[1:0] != 0, set sts_err and go to DONE with no BRAM access.
  - Else if len = 0, go to DONE.
  - Else go to RUN.
- RUN:
  - One access per cycle for len cycles: bram_addr = start + 4k, for k = 0..len-1.
  - Address wraps modulo 2^ADDR_WIDTH; wrap is not an error.
  - Write (cmd_op=0): bram_we = 4'hF, bram_din = cmd_wdata + k (mod 2^32); sts_count increments per write. After the last write, go to DONE.
  - Read (cmd_op=1): bram_we = 0. After the last issue, go to DRAIN.
- DRAIN:
  - A RD_LAT-deep valid shift register tracks reads in flight.
  - Each returning word is added to sts_sum (mod 2^32) and increments sts_count.
  - Go to DONE when no reads are in flight.
- DONE:
  - irq = 1 for exactly one cycle.
  - Next edge: sts_busy = 0, sts_done = 1, return to IDLE.
- cmd_start while sts_busy = 1 is ignored; latched parameters are unchanged.
- ARESETN low at any edge, including mid-RUN or mid-DRAIN: state goes to IDLE and all outputs are zero at that edge. No further BRAM access; in-flight read data is discarded.

## Timing
- Reset value of every output is 0.
- cmd_start is sampled at edge 0. The first bram_en is high in the cycle after edge 0 (cycle 1).
- Write of N words: bram_en high in cycles 1..N; irq in cycle N+1; sts_done = 1 and sts_busy = 0 from cycle N+2.
- Read of N words: last issue in cycle N; last data accumulated at the end of cycle N+RD_LAT; irq in cycle N+RD_LAT+1.
- Error or len = 0: irq in cycle 1; sts_done from cycle 2.
- All outputs are registered; bram_dout is the only input sampled combinationally.

## Configuration
- MEM_CTRL_VERIFY_EN defined: during read, each returned word k is compared with cmd_wdata + k. sts_mismatch counts inequalities and saturates at all-ones.
- MEM_CTRL_VERIFY_EN undefined: compare logic is absent. sts_mismatch stays present and is tied to 0.

## Test plan
- Write fill, addr 0x000, len 4, wdata 0x1 -> BRAM writes 1,2,3,4 at 0x0,0x4,0x8,0xC in cycles 1-4; irq in cycle 5; sts_count = 4.
- Read back the same 4 words (RD_LAT = 1 and RD_LAT = 2) -> sts_sum = 0xA, sts_count = 4; sts_mismatch = 0 (2 after corrupting two words, with VERIFY_EN).
- ADDR_WIDTH = 12, addr 0xFFC, len 2, write -> addresses 0xFFC then 0x000; sts_err = 0.
- addr 0x002 -> no bram_en; sts_err = 1; irq in cycle 1. len = 0 -> no bram_en; sts_done = 1; sts_err = 0.
- Second cmd_start during a len-8 write -> ignored; exactly 8 writes from the original parameters.
- ARESETN low in write cycle 3 -> at that edge bram_en = 0, sts_busy = 0, all status = 0; a following command runs normally.

Source files
------------

// File: rtl/mem_ctrl_cmd_engine.sv
// Multi-word BRAM fill (write) / checksum (read) engine behind the mem_ctrl register slave.
// Define MEM_CTRL_VERIFY_EN to add read-compare mismatch counting; otherwise sts_mismatch is tied to 0.
module mem_ctrl_cmd_engine #(
   parameter int ADDR_WIDTH = 12,
   parameter int LEN_WIDTH  = 8,
   parameter int RD_LAT     = 1
) (
   input  logic                  ACLK,
   input  logic                  ARESETN,
   input  logic                  cmd_start,
   input  logic                  cmd_op,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   output logic                  bram_en,
   output logic [3:0]            bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [31:0]           bram_din,
   input  logic [31:0]           bram_dout,
   output logic                  sts_busy,
   output logic                  sts_done,
   output logic                  sts_err,
   output logic [31:0]           sts_sum,
   output logic [LEN_WIDTH-1:0]  sts_count,
   output logic [LEN_WIDTH-1:0]  sts_mismatch,
   output logic                  irq
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t               state, state_d;
   logic                 op_q;
   logic [LEN_WIDTH-1:0] len_q;
   logic [LEN_WIDTH-1:0] issued;
   logic [RD_LAT-1:0]    rd_vld, rd_vld_nxt;
   logic                 accept, issue, rd_ret, misaligned;

   assign misaligned = cmd_addr[1:0] != 2'b00;
   // Bit i set means a read issued i+1 cycles ago; the top bit marks bram_dout valid now.
   assign rd_vld_nxt = (rd_vld << 1) | RD_LAT'(bram_en & ~bram_we[0]);
   assign rd_ret     = rd_vld[RD_LAT-1];

   always_ff @(posedge ACLK) begin
      if (!ARESETN) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d = state;
      accept  = 1'b0;
      issue   = 1'b0;
      unique case (state)
         IDLE: begin
            if (cmd_start) begin
               accept = 1'b1;
               if (misaligned || cmd_len == '0) begin
                  state_d = DONE;
               end else begin
                  state_d = RUN;
                  issue   = 1'b1;
               end
            end
         end
         RUN: begin
            if (issued != len_q) issue = 1'b1;
            else                 state_d = op_q ? DRAIN : DONE;
         end
         DRAIN: begin
            if (!(|rd_vld_nxt)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         op_q      <= 1'b0;
         len_q     <= '0;
         issued    <= '0;
         rd_vld    <= '0;
         bram_en   <= 1'b0;
         bram_we   <= '0;
         bram_addr <= '0;
         bram_din  <= '0;
         sts_busy  <= 1'b0;
         sts_done  <= 1'b0;
         sts_err   <= 1'b0;
         sts_sum   <= '0;
         sts_count <= '0;
         irq       <= 1'b0;
      end else begin
         rd_vld  <= rd_vld_nxt;
         irq     <= (state_d == DONE) && (state != DONE);
         bram_en <= issue;
         bram_we <= '0;
         if (accept) begin
            op_q      <= cmd_op;
            len_q     <= cmd_len;
            issued    <= LEN_WIDTH'(1);
            bram_addr <= cmd_addr;
            bram_din  <= cmd_wdata;
            if (issue && !cmd_op) bram_we <= 4'hF;
            sts_busy  <= 1'b1;
            sts_done  <= 1'b0;
            sts_err   <= misaligned;
            sts_sum   <= '0;
            sts_count <= '0;
         end else begin
            if (issue) begin
               issued    <= issued + 1'b1;
               bram_addr <= bram_addr + ADDR_WIDTH'(4);
               bram_din  <= bram_din + 32'd1;
               if (!op_q) bram_we <= 4'hF;
            end
            if ((bram_en && bram_we[0]) || rd_ret) sts_count <= sts_count + 1'b1;
            if (rd_ret) sts_sum <= sts_sum + bram_dout;
            if (state == DONE) begin
               sts_busy <= 1'b0;
               sts_done <= 1'b1;
            end
         end
      end
   end

`ifdef MEM_CTRL_VERIFY_EN
   logic [31:0] wdata_q;

   // sts_count equals the index of the word returning this cycle.
   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wdata_q      <= '0;
         sts_mismatch <= '0;
      end else if (accept) begin
         wdata_q      <= cmd_wdata;
         sts_mismatch <= '0;
      end else if (rd_ret && (bram_dout != wdata_q + 32'(sts_count)) && (sts_mismatch != '1)) begin
         sts_mismatch <= sts_mismatch + 1'b1;
      end
   end
`else
   assign sts_mismatch = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl_cmd_engine.sv
// Bench for mem_ctrl_cmd_engine: two instances (RD_LAT 1 and 2) on shared stimulus, each with a BRAM model,
// checked cycle by cycle against timing rules and a word-array reference model.
module tb_mem_ctrl_cmd_engine;
   logic        ACLK = 1'b0;
   logic        ARESETN;
   logic        cmd_start, cmd_op;
   logic [7:0]  cmd_len;
   logic [11:0] cmd_addr;
   logic [31:0] cmd_wdata;

   logic        en[2], busy[2], done[2], err[2], irq[2];
   logic [3:0]  we[2];
   logic [11:0] addr[2];
   logic [31:0] din[2], dout[2], sum[2];
   logic [7:0]  cnt[2], mis[2];

   logic [31:0] mdl[1024];
   int          checks = 0;
   int          errors = 0;

`ifdef MEM_CTRL_VERIFY_EN
   localparam bit VER = 1'b1;
`else
   localparam bit VER = 1'b0;
`endif

   typedef struct {
      bit          op;
      int          len;
      logic [11:0] addr;
      logic [31:0] wd;
      logic [31:0] e_sum;
      int          e_cnt;
      bit          e_err;
      int          e_mis;
   } vec_t;

   always #5 ACLK = ~ACLK;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [31:0] mem[1024];
      logic [31:0] p1, p2;

      mem_ctrl_cmd_engine #(.ADDR_WIDTH(12), .LEN_WIDTH(8), .RD_LAT(g + 1)) dut (
         .ACLK(ACLK), .ARESETN(ARESETN),
         .cmd_start(cmd_start), .cmd_op(cmd_op), .cmd_len(cmd_len),
         .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
         .bram_en(en[g]), .bram_we(we[g]), .bram_addr(addr[g]), .bram_din(din[g]),
         .bram_dout(dout[g]),
         .sts_busy(busy[g]), .sts_done(done[g]), .sts_err(err[g]), .sts_sum(sum[g]),
         .sts_count(cnt[g]), .sts_mismatch(mis[g]), .irq(irq[g])
      );

      always @(posedge ACLK) begin
         if (en[g]) begin
            if (we[g] == 4'hF) mem[addr[g][11:2]] <= din[g];
            p1 <= mem[addr[g][11:2]];
         end
         p2 <= p1;
      end
      assign dout[g] = (g == 0) ? p1 : p2;
   end

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the words of a command over a flat word array.
   function automatic void model_cmd(input bit op, input int len, input logic [11:0] a, input logic [31:0] wd,
                                     output logic [31:0] s, output int n, output bit e, output int m);
      s = 32'd0; n = 0; m = 0;
      e = (a[1:0] != 2'b00);
      if (!e) begin
         for (int k = 0; k < len; k++) begin
            int w;
            w = ((int'(a) + 4 * k) % 4096) / 4;
            if (!op) mdl[w] = wd + 32'(k);
            else begin
               s = s + mdl[w];
               if (mdl[w] != wd + 32'(k)) m++;
            end
            n++;
         end
      end
      if (m > 255) m = 255;
      if (!VER) m = 0;
   endfunction

   task automatic check_zero(input string tag);
      for (int g = 0; g < 2; g++) begin
         check($sformatf("%s d%0d en", tag, g),   32'(en[g]),   32'd0);
         check($sformatf("%s d%0d we", tag, g),   32'(we[g]),   32'd0);
         check($sformatf("%s d%0d busy", tag, g), 32'(busy[g]), 32'd0);
         check($sformatf("%s d%0d done", tag, g), 32'(done[g]), 32'd0);
         check($sformatf("%s d%0d err", tag, g),  32'(err[g]),  32'd0);
         check($sformatf("%s d%0d irq", tag, g),  32'(irq[g]),  32'd0);
         check($sformatf("%s d%0d sum", tag, g),  sum[g],       32'd0);
         check($sformatf("%s d%0d cnt", tag, g),  32'(cnt[g]),  32'd0);
         check($sformatf("%s d%0d mis", tag, g),  32'(mis[g]),  32'd0);
      end
   endtask

   // Issues one command at edge 0 and checks every cycle until both instances report done.
   task automatic run_cmd(input bit op, input int len, input logic [11:0] a, input logic [31:0] wd,
                          input logic [31:0] e_sum, input int e_cnt, input bit e_err, input int e_mis,
                          input int restart_c, input string tag);
      int irq_c[2];
      int c_end;
      bit act;
      act = (a[1:0] == 2'b00) && (len > 0);
      for (int g = 0; g < 2; g++)
         irq_c[g] = !act ? 1 : (op ? len + g + 2 : len + 1);
      c_end = irq_c[1] + 1;
      cmd_op = op; cmd_len = 8'(len); cmd_addr = a; cmd_wdata = wd; cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      cmd_op = 1'($urandom); cmd_len = 8'($urandom); cmd_addr = 12'($urandom); cmd_wdata = $urandom;
      for (int c = 1; c <= c_end; c++) begin
         for (int g = 0; g < 2; g++) begin
            bit          en_e;
            logic [11:0] ea;
            logic [31:0] ed;
            en_e = act && (c <= len);
            ea   = a + 12'(4 * (c - 1));
            ed   = wd + 32'(c - 1);
            check($sformatf("%s d%0d c%0d en", tag, g, c), 32'(en[g]), 32'(en_e));
            check($sformatf("%s d%0d c%0d we", tag, g, c), 32'(we[g]), (en_e && !op) ? 32'hF : 32'h0);
            if (en_e) begin
               check($sformatf("%s d%0d c%0d addr", tag, g, c), 32'(addr[g]), 32'(ea));
               if (!op) check($sformatf("%s d%0d c%0d din", tag, g, c), din[g], ed);
            end
            check($sformatf("%s d%0d c%0d irq", tag, g, c),  32'(irq[g]),  32'(c == irq_c[g]));
            check($sformatf("%s d%0d c%0d busy", tag, g, c), 32'(busy[g]), 32'(c <= irq_c[g]));
            check($sformatf("%s d%0d c%0d done", tag, g, c), 32'(done[g]), 32'(c > irq_c[g]));
            if (c == c_end) begin
               check($sformatf("%s d%0d sum", tag, g), sum[g],      e_sum);
               check($sformatf("%s d%0d cnt", tag, g), 32'(cnt[g]), 32'(e_cnt));
               check($sformatf("%s d%0d err", tag, g), 32'(err[g]), 32'(e_err));
               check($sformatf("%s d%0d mis", tag, g), 32'(mis[g]), 32'(e_mis));
            end
         end
         cmd_start = (c == restart_c);
         tick();
      end
      cmd_start = 1'b0;
   endtask

   task automatic model_and_run(input bit op, input int len, input logic [11:0] a, input logic [31:0] wd,
                                input int restart_c, input string tag);
      logic [31:0] s;
      int n, m;
      bit e;
      model_cmd(op, len, a, wd, s, n, e, m);
      run_cmd(op, len, a, wd, s, n, e, m, restart_c, tag);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[11];
      logic [31:0] s;
      int          n, m;
      bit          e;

      vecs[0]  = '{1'b0, 4, 12'h000, 32'h1,        32'h0,        4, 1'b0, 0};
      vecs[1]  = '{1'b1, 4, 12'h000, 32'h1,        32'hA,        4, 1'b0, 0};
      vecs[2]  = '{1'b0, 2, 12'h004, 32'd100,      32'h0,        2, 1'b0, 0};
      vecs[3]  = '{1'b1, 4, 12'h000, 32'h1,        32'd206,      4, 1'b0, VER ? 2 : 0};
      vecs[4]  = '{1'b0, 2, 12'hFFC, 32'h55,       32'h0,        2, 1'b0, 0};
      vecs[5]  = '{1'b1, 2, 12'hFFC, 32'h55,       32'hAB,       2, 1'b0, 0};
      vecs[6]  = '{1'b0, 3, 12'h002, 32'h7,        32'h0,        0, 1'b1, 0};
      vecs[7]  = '{1'b1, 0, 12'h000, 32'h0,        32'h0,        0, 1'b0, 0};
      vecs[8]  = '{1'b0, 2, 12'h010, 32'hFFFFFFFF, 32'h0,        2, 1'b0, 0};
      vecs[9]  = '{1'b1, 2, 12'h010, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 1'b0, 0};
      vecs[10] = '{1'b1, 0, 12'h001, 32'h0,        32'h0,        0, 1'b1, 0};

      ARESETN = 1'b0; cmd_start = 1'b0; cmd_op = 1'b0; cmd_len = '0; cmd_addr = '0; cmd_wdata = '0;
      repeat (3) tick();
      check_zero("reset");
      ARESETN = 1'b1;
      tick();

      for (int i = 0; i < 11; i++) begin
         model_cmd(vecs[i].op, vecs[i].len, vecs[i].addr, vecs[i].wd, s, n, e, m);
         run_cmd(vecs[i].op, vecs[i].len, vecs[i].addr, vecs[i].wd,
                 vecs[i].e_sum, vecs[i].e_cnt, vecs[i].e_err, vecs[i].e_mis, 0, $sformatf("vec%0d", i));
      end

      // Fill the whole memory so later random reads have known contents.
      for (int i = 0; i < 4; i++) model_and_run(1'b0, 255, 12'(i * 12'h3FC), $urandom, 0, $sformatf("fill%0d", i));
      model_and_run(1'b0, 4, 12'hFF0, $urandom, 0, "fill4");

      // A second start during a len-8 write must not disturb it.
      model_and_run(1'b0, 8, 12'h200, 32'hA0, 3, "restart");
      model_and_run(1'b1, 8, 12'h200, 32'hA0, 4, "restart_rd");

      // Reset in write cycle 3: three words reach memory, then everything is cleared.
      cmd_op = 1'b0; cmd_len = 8'd8; cmd_addr = 12'h100; cmd_wdata = 32'h200; cmd_start = 1'b1;
      tick();
      cmd_start = 1'b0;
      tick();
      tick();
      for (int g = 0; g < 2; g++) check($sformatf("rst_pre d%0d en", g), 32'(en[g]), 32'd1);
      ARESETN = 1'b0;
      tick();
      check_zero("rst_mid");
      ARESETN = 1'b1;
      for (int k = 0; k < 3; k++) mdl[64 + k] = 32'h200 + 32'(k);
      tick();
      check_zero("rst_after");
      model_and_run(1'b1, 4, 12'h100, 32'h200, 0, "rst_rd");

      for (int i = 0; i < 30; i++) begin
         logic [11:0] a;
         if ($urandom_range(0, 7) == 0) a = 12'($urandom) | 12'h1;
         else                           a = {10'($urandom), 2'b00};
         model_and_run(1'($urandom), $urandom_range(0, 24), a, $urandom, 0, $sformatf("rnd%0d", i));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
